// File: rtl/ulpi_pkg.sv
// ULPI link shared definitions: register-access FSM states, TX command prefixes
// and the extended-address escape code.
// Pure declarations; no ports, no latency, no backpressure.
package ulpi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    EXT_ADDR,
    WDATA,
    STP,
    TURN,
    RDATA,
    DIR_LOW,
    RESP
  } state_t;

  localparam logic [1:0] REG_WRITE     = 2'b10;
  localparam logic [1:0] REG_READ      = 2'b11;
  localparam logic [5:0] EXT_ADDR_CODE = 6'h2F;

  // TX command byte for an immediate-form register access.
  function automatic logic [7:0] tx_cmd(input logic write, input logic [5:0] addr6);
    return {(write ? REG_WRITE : REG_READ), addr6};
  endfunction

endpackage

// File: rtl/ulpi_bus_drv.sv
// ULPI data-bus driver: registered data and output enable feeding a tristate pad.
// Latency: dat_nxt/oe_nxt appear on the pad one clk later; bus_off releases the pad combinationally.
// Backpressure: none; the pad follows the registered value every cycle.
// Ports: clk, rst_n (async active-low); dat_nxt/oe_nxt next-cycle drive value and enable;
//        bus_off forces high-Z immediately (PHY owns the bus); pad is the shared ULPI data bus.
module ulpi_bus_drv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dat_nxt,
  input  logic       oe_nxt,
  input  logic       bus_off,
  inout  wire  [7:0] pad
);

  logic [7:0] dat_q;
  logic       oe_q;

  // Out of reset the link owns the bus and drives idle (8'h00).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= 8'h00;
      oe_q  <= 1'b1;
    end else begin
      dat_q <= dat_nxt;
      oe_q  <= oe_nxt;
    end
  end

  // bus_off is not registered: the link must let go in the same cycle dir rises.
  assign pad = (oe_q && !bus_off) ? dat_q : 8'bzzzz_zzzz;

endmodule

// File: rtl/ulpi_reg_access.sv
// ULPI link register read/write engine (TX command, optional extended address, data, STP / read turnaround).
// Latency: request accepted in IDLE, response pulse on rsp_valid after PHY handshake; errors on timeout/retry exhaustion.
// Backpressure: req_ready only in IDLE with ulpi_dir low; PHY stalls via ulpi_nxt, preempts via ulpi_dir.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_write/req_addr/req_wdata request;
//        rsp_valid/rsp_rdata/rsp_err response; ulpi_dir/ulpi_nxt/ulpi_data/ulpi_stp PHY side.
// Build option: define ULPI_REG_EXT_ADDR_EN to enable extended (8-bit) register addressing.
module ulpi_reg_access
  import ulpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  inout  wire  [7:0] ulpi_data,
  output logic       ulpi_stp
);

  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  state_t           state_q, state_n;
  logic             ready_en_q;
  logic             wr_q, wr_n;
  logic [7:0]       addr_q, addr_n;
  logic [7:0]       wdata_q, wdata_n;
  logic [CNT_W-1:0] tmo_q;
  logic [RTY_W-1:0] rty_q;
  logic             aborted_q;
  logic [7:0]       rdata_q;
  logic             err_q;

  logic             accept, ext_n, bad_addr, tmo_hit, rty_last;
  logic             fail, abort;
  logic [7:0]       drv_dat_n;
  logic             drv_oe_n;

  assign accept   = req_valid && req_ready;
  // Request fields as they will be held next cycle; lets the bus register load CMD on the accept edge.
  assign wr_n     = accept ? req_write : wr_q;
  assign addr_n   = accept ? req_addr  : addr_q;
  assign wdata_n  = accept ? req_wdata : wdata_q;
  assign tmo_hit  = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rty_last = (rty_q == RTY_W'(MAX_RETRY));

`ifdef ULPI_REG_EXT_ADDR_EN
  assign ext_n    = (addr_n >= 8'h2F);
  assign bad_addr = 1'b0;
`else
  assign ext_n    = 1'b0;
  // Without extended addressing, 8'h2F would be misread by the PHY as the escape code.
  assign bad_addr = (addr_n[7:6] != 2'b00) || (addr_n[5:0] == EXT_ADDR_CODE);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    fail    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad_addr) begin
            state_n = RESP;
            fail    = 1'b1;
          end else begin
            state_n = CMD;
          end
        end
      end
      CMD,
`ifdef ULPI_REG_EXT_ADDR_EN
      EXT_ADDR,
`endif
      WDATA: begin
        // dir wins over nxt: the PHY has preempted us with RX traffic.
        if (ulpi_dir) begin
          abort = 1'b1;
          if (rty_last) begin
            state_n = RESP;
            fail    = 1'b1;
          end else begin
            state_n = DIR_LOW;
          end
        end else if (ulpi_nxt) begin
          if (state_q == WDATA)                   state_n = STP;
`ifdef ULPI_REG_EXT_ADDR_EN
          else if (state_q == CMD && ext_n)       state_n = EXT_ADDR;
`endif
          else                                    state_n = wr_q ? WDATA : TURN;
        end else if (tmo_hit) begin
          state_n = RESP;
          fail    = 1'b1;
        end
      end
      STP:   state_n = RESP;
      TURN: begin
        if (ulpi_dir) begin
          state_n = RDATA;
        end else if (tmo_hit) begin
          state_n = RESP;
          fail    = 1'b1;
        end
      end
      RDATA: state_n = DIR_LOW;
      DIR_LOW: begin
        if (!ulpi_dir) begin
          state_n = aborted_q ? CMD : RESP;
        end else if (tmo_hit) begin
          state_n = RESP;
          fail    = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: handshake/strobes from current state, bus drive value for the next state.
  always_comb begin
    req_ready = ready_en_q && (state_q == IDLE) && !ulpi_dir;
    rsp_valid = (state_q == RESP);
    ulpi_stp  = (state_q == STP);
    drv_oe_n  = 1'b1;
    drv_dat_n = 8'h00;
    case (state_n)
      CMD:           drv_dat_n = tx_cmd(wr_n, ext_n ? EXT_ADDR_CODE : addr_n[5:0]);
      EXT_ADDR:      drv_dat_n = addr_n;
      WDATA:         drv_dat_n = wdata_n;
      RDATA, DIR_LOW: drv_oe_n = 1'b0;
      default:       drv_dat_n = 8'h00;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Datapath and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      tmo_q      <= '0;
      rty_q      <= '0;
      aborted_q  <= 1'b0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      wr_q       <= wr_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;

      if (state_n != state_q)  tmo_q <= '0;
      else if (tmo_q != '1)    tmo_q <= tmo_q + CNT_W'(1);

      if (accept)      rty_q <= '0;
      else if (abort)  rty_q <= rty_q + RTY_W'(1);

      if (abort)                                         aborted_q <= 1'b1;
      else if (state_q == DIR_LOW && state_n != DIR_LOW) aborted_q <= 1'b0;

      if (accept) begin
        rdata_q <= 8'h00;
        err_q   <= 1'b0;
      end
      if (state_q == RDATA) rdata_q <= ulpi_data;
      if (fail) begin
        rdata_q <= 8'h00;
        err_q   <= 1'b1;
      end
    end
  end

  ulpi_bus_drv u_bus_drv (
    .clk     (clk),
    .rst_n   (rst_n),
    .dat_nxt (drv_dat_n),
    .oe_nxt  (drv_oe_n),
    .bus_off (ulpi_dir),
    .pad     (ulpi_data)
  );

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: reset, write, read, PHY abort/retry, timeout,
// address range handling and reset during a transfer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ulpi_reg_access;

  logic       clk;
  logic       rst_n;
  logic       req_valid, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, rsp_err, ulpi_stp;
  logic [7:0] rsp_rdata;
  logic       ulpi_dir, ulpi_nxt;
  logic       phy_oe;
  logic [7:0] phy_dat;
  wire  [7:0] ulpi_data;

  int n_tests = 0;
  int n_fail  = 0;

  assign ulpi_data = phy_oe ? phy_dat : 8'bzzzz_zzzz;

  ulpi_reg_access dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ulpi_dir  (ulpi_dir),
    .ulpi_nxt  (ulpi_nxt),
    .ulpi_data (ulpi_data),
    .ulpi_stp  (ulpi_stp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0; phy_oe = 1'b0; phy_dat = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_ready", req_ready, 8'h00);
    chk("rst_valid", rsp_valid, 8'h00);
    chk("rst_err",   rsp_err,   8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_stp",   ulpi_stp,  8'h00);
    chk("rst_bus",   ulpi_data, 8'h00);
    rst_n = 1'b1;
    #1 chk("ready_before_clk", req_ready, 8'h00);
    tick();
    chk("ready_after_clk", req_ready, 8'h01);
    ulpi_dir = 1'b1;
    #1 chk("ready_dir_high", req_ready, 8'h00);
    ulpi_dir = 1'b0;
    tick();

    // Write 0x0A <= 0x55, one stall cycle in WDATA
    issue(1'b1, 8'h0A, 8'h55);
    chk("wr_cmd", ulpi_data, 8'h8A);
    chk("wr_cmd_ready", req_ready, 8'h00);
    ulpi_nxt = 1'b1;
    tick();
    chk("wr_data", ulpi_data, 8'h55);
    ulpi_nxt = 1'b0;
    tick();
    chk("wr_data_hold", ulpi_data, 8'h55);
    chk("wr_no_stp", ulpi_stp, 8'h00);
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    chk("wr_stp", ulpi_stp, 8'h01);
    chk("wr_stp_bus", ulpi_data, 8'h00);
    tick();
    chk("wr_rsp_valid", rsp_valid, 8'h01);
    chk("wr_rsp_err", rsp_err, 8'h00);
    chk("wr_rsp_rdata", rsp_rdata, 8'h00);
    chk("wr_stp_done", ulpi_stp, 8'h00);
    tick();
    chk("wr_valid_pulse", rsp_valid, 8'h00);

    // Read 0x16 -> 0xA3
    issue(1'b0, 8'h16, 8'h00);
    chk("rd_cmd", ulpi_data, 8'hD6);
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    chk("rd_turn_bus", ulpi_data, 8'h00);
    ulpi_dir = 1'b1;
    tick();
    phy_oe = 1'b1; phy_dat = 8'hA3;
    tick();
    phy_oe = 1'b0; phy_dat = 8'h00; ulpi_dir = 1'b0;
    chk("rd_no_valid_yet", rsp_valid, 8'h00);
    tick();
    chk("rd_rsp_valid", rsp_valid, 8'h01);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA3);
    chk("rd_rsp_err", rsp_err, 8'h00);
    chk("rd_bus_back", ulpi_data, 8'h00);
    tick();

    // PHY preempts CMD four times: three retries, then error
    issue(1'b1, 8'h04, 8'h11);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort_cmd%0d", i), ulpi_data, 8'h84);
      ulpi_dir = 1'b1;
      ulpi_nxt = (i == 1);
      tick();
      ulpi_nxt = 1'b0;
      chk($sformatf("abort_stp%0d", i), ulpi_stp, 8'h00);
      if (i < 3) begin
        chk($sformatf("abort_valid%0d", i), rsp_valid, 8'h00);
      end else begin
        chk("abort_rsp_valid", rsp_valid, 8'h01);
        chk("abort_rsp_err", rsp_err, 8'h01);
      end
      ulpi_dir = 1'b0;
      tick();
    end
    chk("abort_idle_ready", req_ready, 8'h01);

    // nxt never arrives: timeout after 64 CMD cycles
    issue(1'b0, 8'h01, 8'h00);
    chk("tmo_cmd", ulpi_data, 8'hC1);
    repeat (63) tick();
    chk("tmo_cycle64_valid", rsp_valid, 8'h00);
    chk("tmo_cycle64_bus", ulpi_data, 8'hC1);
    tick();
    chk("tmo_valid", rsp_valid, 8'h01);
    chk("tmo_err", rsp_err, 8'h01);
    chk("tmo_rdata", rsp_rdata, 8'h00);
    chk("tmo_bus", ulpi_data, 8'h00);
    tick();

    // Read of address 0x85
    issue(1'b0, 8'h85, 8'h00);
`ifdef ULPI_REG_EXT_ADDR_EN
    chk("ext_cmd", ulpi_data, 8'hEF);
    ulpi_nxt = 1'b1;
    tick();
    chk("ext_addr", ulpi_data, 8'h85);
    tick();
    ulpi_nxt = 1'b0;
    ulpi_dir = 1'b1;
    tick();
    phy_oe = 1'b1; phy_dat = 8'h3C;
    tick();
    phy_oe = 1'b0; ulpi_dir = 1'b0;
    tick();
    chk("ext_valid", rsp_valid, 8'h01);
    chk("ext_rdata", rsp_rdata, 8'h3C);
    chk("ext_err", rsp_err, 8'h00);
    tick();
`else
    chk("ext_valid", rsp_valid, 8'h01);
    chk("ext_err", rsp_err, 8'h01);
    chk("ext_bus", ulpi_data, 8'h00);
    tick();
    issue(1'b1, 8'h2F, 8'h99);
    chk("esc_valid", rsp_valid, 8'h01);
    chk("esc_err", rsp_err, 8'h01);
    chk("esc_bus", ulpi_data, 8'h00);
    tick();
`endif

    // Reset asserted during WDATA
    issue(1'b1, 8'h0A, 8'h77);
    ulpi_nxt = 1'b1;
    tick();
    ulpi_nxt = 1'b0;
    chk("rstmid_wdata", ulpi_data, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("rstmid_bus", ulpi_data, 8'h00);
    chk("rstmid_stp", ulpi_stp, 8'h00);
    chk("rstmid_valid", rsp_valid, 8'h00);
    chk("rstmid_ready", req_ready, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_no_valid", rsp_valid, 8'h00);
    chk("rstmid_ready_back", req_ready, 8'h01);
    issue(1'b1, 8'h0A, 8'h5A);
    chk("post_cmd", ulpi_data, 8'h8A);
    ulpi_nxt = 1'b1;
    tick();
    chk("post_data", ulpi_data, 8'h5A);
    tick();
    ulpi_nxt = 1'b0;
    chk("post_stp", ulpi_stp, 8'h01);
    tick();
    chk("post_valid", rsp_valid, 8'h01);
    chk("post_err", rsp_err, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_access.md
ULPI_REG_ACCESS -- requirements
Module: ulpi_reg_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles waiting for ulpi_nxt or ulpi_dir before a request fails.
REQ-002 Parameter MAX_RETRY, default 3: PHY-abort retries before error.
REQ-003 Parameter CNT_W, default 8: width of timeout counter; SHALL be >= clog2(TIMEOUT_CYCLES+1).
REQ-004 Ports, clock and reset first: clk in 1 (single clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-005 req_valid in 1; req_ready out 1; req_write in 1 (1=write, 0=read); req_addr in 8; req_wdata in 8.
REQ-006 rsp_valid out 1 (one-cycle pulse); rsp_rdata out 8; rsp_err out 1 (timeout or retries exhausted).
REQ-007 ulpi_dir in 1; ulpi_nxt in 1; ulpi_data inout 8; ulpi_stp out 1.

Function
REQ-008 States: IDLE, CMD, EXT_ADDR, WDATA, STP, TURN, RDATA, DIR_LOW, RESP.
REQ-009 req_ready=1 only in IDLE with ulpi_dir=0; req_valid&req_ready captures write/addr/wdata, moves to CMD next cycle.
REQ-010 CMD drives ulpi_data={write?2'b10:2'b11, addr6}; addr6=req_addr[5:0], or 6'h2F when extended addressing applies (REQ-026).
REQ-011 CMD holds data until ulpi_nxt=1, then -> EXT_ADDR (extended), WDATA (write) or TURN (read).
REQ-012 EXT_ADDR drives full req_addr until ulpi_nxt=1, then -> WDATA or TURN.
REQ-013 WDATA drives wdata until ulpi_nxt=1, then -> STP.
REQ-014 STP drives ulpi_stp=1 and ulpi_data=8'h00 exactly one cycle, then -> RESP with rsp_err=0.
REQ-015 TURN: wait for ulpi_dir=1, release bus (ulpi_data=Z) same edge, -> RDATA.
REQ-016 RDATA: sample ulpi_data into rsp_rdata one cycle after dir rise (turnaround cycle skipped), -> DIR_LOW.
REQ-017 DIR_LOW: wait ulpi_dir=0; link drives bus again from cycle after dir falls; -> RESP.
REQ-018 RESP: rsp_valid=1 one cycle, -> IDLE; write response rsp_rdata=8'h00.
REQ-019 Abort: ulpi_dir=1 in CMD, EXT_ADDR or WDATA before nxt = PHY RX preemption; release bus, wait dir=0, retry from CMD; retry counter increments.
REQ-020 Retry count > MAX_RETRY -> RESP with rsp_err=1; ulpi_stp never asserted on abort.
REQ-021 Timeout counter clears on state entry; reaching TIMEOUT_CYCLES in CMD/EXT_ADDR/WDATA/TURN/DIR_LOW -> RESP with rsp_err=1, bus released, rsp_rdata=8'h00.
REQ-022 ulpi_nxt and ulpi_dir same cycle in CMD: treat as abort (dir wins).
REQ-023 Link drives ulpi_data (8'h00 in IDLE) whenever ulpi_dir=0 and not waiting post-abort; Z whenever ulpi_dir=1.

Reset
REQ-024 rst_n=0 asynchronously: state=IDLE, req_ready=0 until first clk after release, rsp_valid=0, rsp_err=0, rsp_rdata=8'h00, ulpi_stp=0, ulpi_data output=8'h00 enabled, counters=0.
REQ-025 Reset mid-transfer aborts without stp and without rsp_valid.

Configuration
REQ-026 ULPI_REG_EXT_ADDR_EN defined: req_addr>=8'h2F uses immediate 6'h2F plus EXT_ADDR byte; req_addr<8'h2F uses immediate form.
REQ-027 ULPI_REG_EXT_ADDR_EN undefined: EXT_ADDR state absent; req_addr[7:6]!=0 or req_addr[5:0]==6'h2F -> RESP with rsp_err=1 next cycle, no bus activity.

Structure
REQ-028 Package ulpi_pkg: state enum, TX command prefixes (REG_WRITE=2'b10, REG_READ=2'b11), EXT_ADDR_CODE=6'h2F.
REQ-029 Sub-module ulpi_bus_drv: tristate output register with enable, shared with other ULPI link blocks.

Verification
REQ-030 Write addr 8'h0A data 8'h55, nxt asserted 1 cycle after each drive -> bus 8'h8A, 8'h55, stp pulse with 8'h00, rsp_valid, rsp_err=0.
REQ-031 Read addr 8'h16, PHY dir rises after nxt, data 8'hA3 cycle after turnaround -> rsp_rdata=8'hA3, rsp_err=0.
REQ-032 Dir asserted in CMD 4 times consecutively (MAX_RETRY=3) -> three retries, then rsp_err=1, stp never high.
REQ-033 nxt held low 64 cycles in CMD -> rsp_err=1 on cycle 65, bus 8'h00.
REQ-034 With ULPI_REG_EXT_ADDR_EN, read addr 8'h85 -> bus 8'hEF then 8'h85; without it -> immediate rsp_err=1.
REQ-035 rst_n low during WDATA -> outputs at reset values immediately, no rsp_valid, next request completes normally.
